// File: rtl/dmem_stall_responder.sv
// Multi-cycle word-addressed data memory with a Stall/Done handshake.
// One request is latched at a time; the access is performed LATENCY cycles
// after acceptance and reported with a one-cycle Done (plus err for illegal
// requests, which complete in one cycle without touching storage).
module dmem_stall_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        err
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [15:0]           lat_data;
  logic                  lat_wr;
  logic [15:0]           mem [DEPTH];

  logic                  req;
  logic                  illegal;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_unused;

  assign idx         = Addr[DEPTH_LOG2:1];
  assign addr_unused = ^Addr[15:DEPTH_LOG2+1];

  // Request decode and combinational stall (only legal requests stall in IDLE)
  always_comb begin
    req     = Rd | Wr;
    illegal = (Rd & Wr) | Addr[0];
    Stall   = (state == BUSY) || ((state == IDLE) && req && !illegal);
  end

  // Handshake FSM, latency counter, storage and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      DataOut  <= '0;
      Done     <= 1'b0;
      err      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      Done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              Done <= 1'b1;
              err  <= 1'b1;
            end else begin
              lat_idx  <= idx;
              lat_data <= DataIn;
              lat_wr   <= Wr;
              cnt      <= CNT_LOAD;
              // Single-cycle latency performs the access from the live inputs
              if (LATENCY == 1) begin
                if (Wr) begin
                  mem[idx] <= DataIn;
                end else begin
                  DataOut <= mem[idx];
                end
                Done <= 1'b1;
              end else begin
                state <= BUSY;
              end
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (lat_wr) begin
              mem[lat_idx] <= lat_data;
            end else begin
              DataOut <= mem[lat_idx];
            end
            Done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Bench for dmem_stall_responder: a LATENCY=4 and a LATENCY=1 instance are
// driven cycle by cycle and compared against a cycle-numbered reference model
// (completion cycle = acceptance cycle + latency, flat storage array).
module tb_dmem_stall_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [15:0] addr_i [2];
  logic [15:0] din_i  [2];
  logic [15:0] dout_o [2];
  logic        stall_o[2];
  logic        done_o [2];
  logic        err_o  [2];

  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state, per instance
  logic [15:0] mmem    [2][256];
  logic [15:0] mdout   [2];
  int          pend_cyc[2];
  logic        pend_err[2];
  logic        pend_ld [2];
  logic [15:0] pend_dat[2];
  int          free_at [2];
  int          lat     [2];
  int          cyc = 0;

  always #5 clk = ~clk;

  dmem_stall_responder #(.LATENCY(4), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .Addr(addr_i[0]), .DataIn(din_i[0]),
    .Rd(rd_i[0]), .Wr(wr_i[0]), .DataOut(dout_o[0]),
    .Stall(stall_o[0]), .Done(done_o[0]), .err(err_o[0])
  );

  dmem_stall_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_lat1 (
    .clk(clk), .rst(rst), .Addr(addr_i[1]), .DataIn(din_i[1]),
    .Rd(rd_i[1]), .Wr(wr_i[1]), .DataOut(dout_o[1]),
    .Stall(stall_o[1]), .Done(done_o[1]), .err(err_o[1])
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mmem[k][i] = '0;
      mdout[k]    = '0;
      pend_cyc[k] = -1;
      pend_err[k] = 1'b0;
      pend_ld[k]  = 1'b0;
      pend_dat[k] = '0;
      free_at[k]  = 0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle, released after the next rising edge
  task automatic do_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = '0; din_i[k] = '0;
    end
    rst = 1'b1;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d rst dout", k), dout_o[k], 16'h0);
      check($sformatf("d%0d rst done", k), 16'(done_o[k]), 16'h0);
      check($sformatf("d%0d rst err", k), 16'(err_o[k]), 16'h0);
      check($sformatf("d%0d rst stall", k), 16'(stall_o[k]), 16'h0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // One cycle: check registered outputs, drive inputs to instance sel, check Stall
  task automatic step(input int sel, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    logic        exp_done, exp_err, exp_stall, busy;
    logic        rr, ww;
    logic [15:0] aa, dd;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (pend_cyc[k] == cyc) begin
        exp_done = 1'b1;
        exp_err  = pend_err[k];
        if (pend_ld[k]) mdout[k] = pend_dat[k];
      end
      check($sformatf("d%0d done", k), 16'(done_o[k]), 16'(exp_done));
      check($sformatf("d%0d err", k), 16'(err_o[k]), 16'(exp_err));
      check($sformatf("d%0d dout", k), dout_o[k], mdout[k]);
    end
    for (int k = 0; k < 2; k++) begin
      rd_i[k]   = (k == sel) ? r : 1'b0;
      wr_i[k]   = (k == sel) ? w : 1'b0;
      addr_i[k] = (k == sel) ? a : 16'h0;
      din_i[k]  = (k == sel) ? d : 16'h0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      rr = rd_i[k]; ww = wr_i[k]; aa = addr_i[k]; dd = din_i[k];
      busy = (cyc < free_at[k]);
      exp_stall = busy;
      if (!busy && (rr || ww)) begin
        if ((rr && ww) || aa[0]) begin
          exp_stall   = 1'b0;
          pend_cyc[k] = cyc + 1;
          pend_err[k] = 1'b1;
          pend_ld[k]  = 1'b0;
        end else begin
          exp_stall   = 1'b1;
          free_at[k]  = cyc + lat[k];
          pend_cyc[k] = cyc + lat[k];
          pend_err[k] = 1'b0;
          pend_ld[k]  = rr;
          if (ww) mmem[k][aa[8:1]] = dd;
          else    pend_dat[k] = mmem[k][aa[8:1]];
        end
      end
      check($sformatf("d%0d stall", k), 16'(stall_o[k]), 16'(exp_stall));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rand_step(input int sel);
    int          op;
    logic [15:0] a;
    op   = $urandom_range(0, 7);
    a    = 16'($urandom);
    a[8:1] = 8'($urandom_range(0, 15));
    a[0] = ($urandom_range(0, 7) == 0);
    step(sel, (op >= 2 && op <= 4) || op == 7, (op >= 5), a, 16'($urandom));
  endtask

  initial begin
    lat[0] = 4;
    lat[1] = 1;
    for (int k = 0; k < 2; k++) begin
      rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = '0; din_i[k] = '0;
    end
    model_clear();
    #5;
    do_reset();

    // Load from cleared storage
    step(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    idle(4);
    // Store then back-to-back load in the Done cycle
    step(0, 1'b0, 1'b1, 16'h0024, 16'hBEEF);
    idle(3);
    step(0, 1'b1, 1'b0, 16'h0024, 16'h0);
    idle(4);
    // Misaligned load and Rd&Wr collision
    step(0, 1'b1, 1'b0, 16'h0025, 16'h0);
    idle(1);
    step(0, 1'b1, 1'b1, 16'h0024, 16'h5555);
    idle(1);
    step(0, 1'b1, 1'b0, 16'h0024, 16'h0);
    idle(4);
    // Inputs scrambled while busy
    step(0, 1'b0, 1'b1, 16'h0002, 16'h1234);
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom), 1'b1, 16'($urandom_range(0, 63)) & 16'hFFFE, 16'($urandom));
    step(0, 1'b1, 1'b0, 16'h0002, 16'h0);
    idle(4);
    step(0, 1'b1, 1'b0, 16'h0004, 16'h0);
    idle(4);
    // Reset during a pending store
    step(0, 1'b0, 1'b1, 16'h0008, 16'hAAAA);
    idle(2);
    do_reset();
    idle(2);
    step(0, 1'b1, 1'b0, 16'h0008, 16'h0);
    idle(4);

    // Randomized traffic on the LATENCY=4 instance
    for (int i = 0; i < 200; i++) rand_step(0);
    idle(5);

    // LATENCY=1: alternating store/load every cycle
    for (int i = 0; i < 8; i++) begin
      step(1, 1'b0, 1'b1, 16'(2 * (i % 4)), 16'hC000 + 16'(i));
      step(1, 1'b1, 1'b0, 16'(2 * (i % 4)), 16'h0);
    end
    idle(2);

    // Randomized traffic on the LATENCY=1 instance
    for (int i = 0; i < 200; i++) rand_step(1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
